// File: rtl/vote_pkg.sv
// Shared constants and types for the voting-machine button front-end and core.
package vote_pkg;

  localparam int NUM_CANDIDATES = 4;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    HOLDOFF      = 2'd2
  } cond_state_e;

  function automatic logic [CNT_W-1:0] cnt_of(input int n);
    return CNT_W'(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button lane: 2-flop synchroniser followed by a stable-count debouncer.
module btn_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o
);

  localparam logic [CNT_W-1:0] DEB_LIM = cnt_of(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_CNT = cnt_of(1);

  logic             meta_q;
  logic             sync_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + ONE_CNT;

  // Any sample agreeing with the current level restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_inc_s == DEB_LIM) begin
        deb_d = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/vote_button_conditioner.sv
// Conditions raw candidate buttons into single-cycle, one-at-a-time press strobes.
// Optional press statistics counters are enabled with `define VOTE_COND_PRESS_CNT_EN.
module vote_button_conditioner
  import vote_pkg::*;
#(
  parameter int NUM_BTN         = NUM_CANDIDATES,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               multi_press_err,
  output logic               busy
`ifdef VOTE_COND_PRESS_CNT_EN
  ,
  output logic [15:0]        accepted_cnt,
  output logic [7:0]         rejected_cnt
`endif
);

  localparam logic [CNT_W-1:0]   HOLD_LIM = cnt_of(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0]   ONE_CNT  = cnt_of(1);
  localparam logic [NUM_BTN-1:0] ONE_BTN  = NUM_BTN'(1);

  logic [NUM_BTN-1:0] deb_s;
  logic [NUM_BTN-1:0] deb_dly_q;
  logic [NUM_BTN-1:0] rise_s;
  logic               multi_s;

  cond_state_e        state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               err_q, err_d;
  logic               busy_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw_i (btn_raw[i]),
      .deb_o (deb_s[i])
    );
  end

  assign rise_s  = deb_s & ~deb_dly_q;
  // Clearing the lowest set bit leaves something only when two or more rose.
  assign multi_s = ((rise_s & (rise_s - ONE_BTN)) != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s != '0) begin
          if (multi_s) begin
            err_d = 1'b1;
          end else begin
            pulse_d = rise_s;
          end
          state_d = WAIT_RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (deb_s == '0) begin
          if (HOLD_LIM == '0) begin
            state_d = IDLE;
          end else begin
            hold_d  = HOLD_LIM;
            state_d = HOLDOFF;
          end
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      HOLDOFF: begin
        if (deb_s != '0) begin
          state_d = WAIT_RELEASE;
        end else if (hold_q == ONE_CNT) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - ONE_CNT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pulse_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      deb_dly_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
      busy_q    <= (state_d != IDLE);
      deb_dly_q <= deb_s;
    end
  end

  assign btn_pulse       = pulse_q;
  assign multi_press_err = err_q;
  assign busy            = busy_q;

`ifdef VOTE_COND_PRESS_CNT_EN
  logic [15:0] acc_q;
  logic [7:0]  rej_q;

  // Accepted presses wrap; rejections saturate so a stuck fault stays visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 16'h0000;
      rej_q <= 8'h00;
    end else begin
      if (pulse_d != '0) begin
        acc_q <= acc_q + 16'h0001;
      end
      if (err_d && (rej_q != 8'hFF)) begin
        rej_q <= rej_q + 8'h01;
      end
    end
  end

  assign accepted_cnt = acc_q;
  assign rejected_cnt = rej_q;
`endif

endmodule
